// File: rtl/img_pkg.sv
// Shared definitions for the image-processing engine: opcodes, geometry and
// the scheduler state encoding.
package img_pkg;

    localparam int IMG_DIM = 64;
    localparam int COORD_W = 6;
    localparam int PIX_W   = 24;
    localparam int OP_W    = 2;

    localparam logic [OP_W-1:0] OP_MIRROR  = 2'd0;
    localparam logic [OP_W-1:0] OP_GRAY    = 2'd1;
    localparam logic [OP_W-1:0] OP_SHARPEN = 2'd2;
    localparam logic [OP_W-1:0] OP_COPY    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOST  = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sched_cmd_fifo.sv
// Small synchronous opcode FIFO; full/empty come straight from the registered
// count so a same-cycle pop never frees a slot early.
module sched_cmd_fifo
    import img_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [OP_W-1:0]  din,
    input  logic             pop,
    output logic [OP_W-1:0]  dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [OP_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/img_op_scheduler.sv
// Command sequencer for the image engine: queues opcodes, starts one run per
// command under a watchdog, and arbitrates the image-memory port with the host.
module img_op_scheduler
    import img_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16384
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [OP_W-1:0]    cmd_op,
    output logic               cmd_ready,
    output logic               eng_start,
    output logic [OP_W-1:0]    eng_op,
    output logic               eng_abort,
    input  logic               eng_done,
    input  logic [COORD_W-1:0] eng_row,
    input  logic [COORD_W-1:0] eng_col,
    input  logic               eng_we,
    input  logic [PIX_W-1:0]   eng_pix,
    input  logic               host_req,
    output logic               host_gnt,
    input  logic [COORD_W-1:0] host_row,
    input  logic [COORD_W-1:0] host_col,
    input  logic               host_we,
    input  logic [PIX_W-1:0]   host_pix,
    output logic [COORD_W-1:0] mem_row,
    output logic [COORD_W-1:0] mem_col,
    output logic               mem_we,
    output logic [PIX_W-1:0]   mem_pix,
    output logic               busy,
    output logic               err,
    input  logic               err_clr,
    output logic [7:0]         ops_done
);

    localparam int               TMR_W   = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);
    localparam int               CNT_W   = $clog2(DEPTH) + 1;

    sched_state_t     state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [OP_W-1:0]  eng_op_q, eng_op_d;
    logic             err_q, err_d;
    logic [7:0]       ops_done_q, ops_done_d;

    logic             fifo_full, fifo_empty, fifo_pop;
    logic [OP_W-1:0]  fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             run_done, run_timeout;

    sched_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .din   (cmd_op),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cmd_ready   = !fifo_full;
    assign fifo_pop    = (state_q == ST_START) && !fifo_empty;
    assign run_done    = (state_q == ST_RUN) && eng_done;
    assign run_timeout = (state_q == ST_RUN) && !eng_done && (timer_q == TMR_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            eng_op_q   <= '0;
            err_q      <= 1'b0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            eng_op_q   <= eng_op_d;
            err_q      <= err_d;
            ops_done_q <= ops_done_d;
        end
    end

    // Host is checked first in IDLE so a request held off by a run wins next.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (host_req)                state_d = ST_HOST;
                else if (fifo_count != '0)   state_d = ST_START;
            end
            ST_HOST:  if (!host_req) state_d = ST_IDLE;
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (run_done || run_timeout) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        timer_d    = timer_q;
        eng_op_d   = eng_op_q;
        ops_done_d = ops_done_q + 8'(run_done);
        err_d      = run_timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
        if (state_q == ST_START) begin
            timer_d  = '0;
            eng_op_d = fifo_head;
        end else if (state_q == ST_RUN) begin
            timer_d  = timer_q + TMR_W'(1);
        end
    end

    always_comb begin
        eng_start = (state_q == ST_START);
        eng_abort = run_timeout;
        host_gnt  = (state_q == ST_HOST);
        busy      = (state_q == ST_START) || (state_q == ST_RUN);
        eng_op    = (state_q == ST_START) ? fifo_head : eng_op_q;
        err       = err_q;
        ops_done  = ops_done_q;
        mem_row   = '0;
        mem_col   = '0;
        mem_we    = 1'b0;
        mem_pix   = '0;
        if (state_q == ST_HOST) begin
            mem_row = host_row;
            mem_col = host_col;
            mem_we  = host_we;
            mem_pix = host_pix;
        end else if (state_q == ST_RUN) begin
            mem_row = eng_row;
            mem_col = eng_col;
            mem_we  = eng_we;
            mem_pix = eng_pix;
        end
    end

endmodule

// File: tb/tb_img_op_scheduler.sv
// Directed bench for img_op_scheduler: a long-timeout instance for the
// sequencing/arbitration scenarios and a TIMEOUT=16 instance for the watchdog.
module tb_img_op_scheduler;

    logic        clk, rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        eng_done;
    logic [5:0]  eng_row, eng_col, host_row, host_col;
    logic        eng_we, host_we, host_req, err_clr;
    logic [23:0] eng_pix, host_pix;

    logic        cmd_ready, eng_start, eng_abort, host_gnt, mem_we, busy, err;
    logic [1:0]  eng_op;
    logic [5:0]  mem_row, mem_col;
    logic [23:0] mem_pix;
    logic [7:0]  ops_done;

    logic        t_cmd_ready, t_eng_start, t_eng_abort, t_host_gnt, t_mem_we, t_busy, t_err;
    logic [1:0]  t_eng_op;
    logic [5:0]  t_mem_row, t_mem_col;
    logic [23:0] t_mem_pix;
    logic [7:0]  t_ops_done;

    int checks = 0;
    int errors = 0;

    img_op_scheduler #(.DEPTH(4), .TIMEOUT(16384)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .eng_start(eng_start), .eng_op(eng_op), .eng_abort(eng_abort), .eng_done(eng_done),
        .eng_row(eng_row), .eng_col(eng_col), .eng_we(eng_we), .eng_pix(eng_pix),
        .host_req(host_req), .host_gnt(host_gnt), .host_row(host_row), .host_col(host_col),
        .host_we(host_we), .host_pix(host_pix), .mem_row(mem_row), .mem_col(mem_col),
        .mem_we(mem_we), .mem_pix(mem_pix), .busy(busy), .err(err), .err_clr(err_clr),
        .ops_done(ops_done)
    );

    img_op_scheduler #(.DEPTH(4), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(t_cmd_ready),
        .eng_start(t_eng_start), .eng_op(t_eng_op), .eng_abort(t_eng_abort), .eng_done(eng_done),
        .eng_row(eng_row), .eng_col(eng_col), .eng_we(eng_we), .eng_pix(eng_pix),
        .host_req(host_req), .host_gnt(t_host_gnt), .host_row(host_row), .host_col(host_col),
        .host_we(host_we), .host_pix(host_pix), .mem_row(t_mem_row), .mem_col(t_mem_col),
        .mem_we(t_mem_we), .mem_pix(t_mem_pix), .busy(t_busy), .err(t_err), .err_clr(err_clr),
        .ops_done(t_ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks sample 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; eng_done = 1'b0; host_req = 1'b0; err_clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_start(input bit use_t, input string name);
        int k = 0;
        while (!(use_t ? t_eng_start : eng_start) && k < 40) begin
            step(); #1;
            k++;
        end
        checks++;
        if (!(use_t ? t_eng_start : eng_start)) begin
            errors++;
            $display("FAIL %s: eng_start not seen within 40 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); #1;
        checks++;
        if ({cmd_ready, eng_start, eng_op, eng_abort, host_gnt, busy, err, ops_done} !== {1'b1, 15'd0}) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 1 then zeros", {cmd_ready, eng_start, eng_op, eng_abort, host_gnt, busy, err, ops_done});
        end
        checks++;
        if ({mem_row, mem_col, mem_we, mem_pix} !== 37'd0) begin
            errors++;
            $display("FAIL reset_mem: got %h want 0", {mem_row, mem_col, mem_we, mem_pix});
        end
        checks++;
        if ({t_cmd_ready, t_eng_start, t_busy, t_err, t_ops_done} !== {1'b1, 11'd0}) begin
            errors++;
            $display("FAIL reset_to: got %b want 1 then zeros", {t_cmd_ready, t_eng_start, t_busy, t_err, t_ops_done});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_op();
        cmd_valid = 1'b1; cmd_op = 2'd1; #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", cmd_ready); end
        step();
        cmd_valid = 1'b0; #1;
        checks++;
        if (eng_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b want 0", eng_start); end
        step(); #1;
        checks++;
        if ({eng_start, eng_op, busy} !== 4'b1011) begin
            errors++; $display("FAIL single_start: start/op/busy got %b want 1011", {eng_start, eng_op, busy});
        end
        step();
        eng_row = 6'd33; eng_col = 6'd63; eng_we = 1'b1; eng_pix = 24'hc0ffee; #1;
        checks++;
        if ({eng_start, eng_op} !== 3'b001) begin errors++; $display("FAIL single_run_op: got %b want 001", {eng_start, eng_op}); end
        checks++;
        if ({mem_row, mem_col, mem_we, mem_pix} !== {6'd33, 6'd63, 1'b1, 24'hc0ffee}) begin
            errors++; $display("FAIL single_mem: got %h want engine bus", {mem_row, mem_col, mem_we, mem_pix});
        end
        repeat (99) step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0; #1;
        checks++;
        if ({busy, ops_done} !== 9'd1) begin errors++; $display("FAIL single_done: busy/ops got %h want 001", {busy, ops_done}); end
    endtask

    task automatic test_fifo_full();
        host_req = 1'b1;
        host_row = 6'd5; host_col = 6'd6; host_we = 1'b1; host_pix = 24'h00a5a5;
        step(); #1;
        checks++;
        if ({host_gnt, mem_row, mem_col, mem_we, mem_pix} !== {1'b1, 6'd5, 6'd6, 1'b1, 24'h00a5a5}) begin
            errors++; $display("FAIL full_host_bus: got %h want host bus", {host_gnt, mem_row, mem_col, mem_we, mem_pix});
        end
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'(i);
            step();
        end
        cmd_valid = 1'b0; #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = 2'd2;
        step();
        cmd_valid = 1'b0; host_req = 1'b0;
        step(); #1;
        checks++;
        if ({host_gnt, cmd_ready} !== 2'b00) begin errors++; $display("FAIL full_release: gnt/ready got %b want 00", {host_gnt, cmd_ready}); end
        step(); #1;
        checks++;
        if ({eng_start, eng_op, cmd_ready} !== 4'b1000) begin
            errors++; $display("FAIL full_first_start: start/op/ready got %b want 1000", {eng_start, eng_op, cmd_ready});
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                wait_start(1'b0, "full_order_start");
                checks++;
                if (eng_op !== 2'(i)) begin errors++; $display("FAIL full_order: got op %0d want %0d", eng_op, i); end
            end
            step(); #1;
            if (i == 0) begin
                checks++;
                if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b want 1", cmd_ready); end
            end
            repeat (2) step();
            eng_done = 1'b1;
            step();
            eng_done = 1'b0;
        end
        repeat (6) begin
            step(); #1;
            checks++;
            if (eng_start !== 1'b0) begin errors++; $display("FAIL full_dropped_push: got start %b want 0", eng_start); end
        end
        checks++;
        if (ops_done !== 8'd5) begin errors++; $display("FAIL full_ops: got %0d want 5", ops_done); end
    endtask

    task automatic test_arbitration();
        cmd_valid = 1'b1; cmd_op = 2'd2;
        step();
        cmd_valid = 1'b0; #1;
        wait_start(1'b0, "arb_start");
        step();
        cmd_valid = 1'b1; cmd_op = 2'd3; host_req = 1'b1;
        eng_row = 6'd7; eng_col = 6'd9; eng_we = 1'b1; eng_pix = 24'h123456;
        host_row = 6'd1; host_col = 6'd2; host_we = 1'b0; host_pix = 24'habcdef;
        step();
        cmd_valid = 1'b0; #1;
        checks++;
        if ({host_gnt, mem_row, mem_col, mem_we, mem_pix} !== {1'b0, 6'd7, 6'd9, 1'b1, 24'h123456}) begin
            errors++; $display("FAIL arb_held_off: got %h want engine bus", {host_gnt, mem_row, mem_col, mem_we, mem_pix});
        end
        eng_done = 1'b1;
        step();
        eng_done = 1'b0; #1;
        checks++;
        if ({busy, host_gnt, eng_start, mem_row, mem_we, mem_pix} !== 33'd0) begin
            errors++; $display("FAIL arb_gap: got %h want 0", {busy, host_gnt, eng_start, mem_row, mem_we, mem_pix});
        end
        step(); #1;
        checks++;
        if ({host_gnt, eng_start, mem_row, mem_col, mem_we, mem_pix} !== {2'b10, 6'd1, 6'd2, 1'b0, 24'habcdef}) begin
            errors++; $display("FAIL arb_host_first: got %h want host bus", {host_gnt, eng_start, mem_row, mem_col, mem_we, mem_pix});
        end
        host_req = 1'b0;
        step(); #1;
        checks++;
        if ({host_gnt, eng_start} !== 2'b00) begin errors++; $display("FAIL arb_release: got %b want 00", {host_gnt, eng_start}); end
        step(); #1;
        checks++;
        if ({eng_start, eng_op} !== 3'b111) begin errors++; $display("FAIL arb_queued: got %b want 111", {eng_start, eng_op}); end
        step(); step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0; #1;
        checks++;
        if (ops_done !== 8'd7) begin errors++; $display("FAIL arb_ops: got %0d want 7", ops_done); end
    endtask

    task automatic test_timeout();
        do_reset();
        cmd_valid = 1'b1; cmd_op = 2'd1;
        step();
        cmd_valid = 1'b0; #1;
        wait_start(1'b1, "to_start");
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 16) err_clr = 1'b1;
            #1;
            checks++;
            if ({t_eng_abort, t_busy, t_err} !== {(c == 16), 2'b10}) begin
                errors++; $display("FAIL to_cycle%0d: abort/busy/err got %b", c, {t_eng_abort, t_busy, t_err});
            end
        end
        step();
        err_clr = 1'b0; #1;
        checks++;
        if ({t_err, t_busy, t_ops_done} !== {1'b1, 9'd0}) begin
            errors++; $display("FAIL to_after: err/busy/ops got %h want 100", {t_err, t_busy, t_ops_done});
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0; #1;
        checks++;
        if (t_err !== 1'b0) begin errors++; $display("FAIL to_err_clr: got %b want 0", t_err); end
    endtask

    task automatic test_collision();
        do_reset();
        cmd_valid = 1'b1; cmd_op = 2'd0;
        step();
        cmd_valid = 1'b0; #1;
        wait_start(1'b1, "col_start");
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 16) eng_done = 1'b1;
        end
        #1;
        checks++;
        if (t_eng_abort !== 1'b0) begin errors++; $display("FAIL col_abort: got %b want 0", t_eng_abort); end
        step();
        eng_done = 1'b0; #1;
        checks++;
        if ({t_err, t_busy, t_ops_done} !== {2'b00, 8'd1}) begin
            errors++; $display("FAIL col_after: err/busy/ops got %h want 001", {t_err, t_busy, t_ops_done});
        end
    endtask

    task automatic test_reset_mid_run();
        bit bad = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd2;
        step();
        cmd_valid = 1'b0; #1;
        wait_start(1'b0, "mid_start");
        for (int i = 1; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'(i);
            step();
        end
        cmd_valid = 1'b0;
        rst = 1'b1;
        step(); #1;
        checks++;
        if ({cmd_ready, eng_start, eng_op, eng_abort, host_gnt, busy, err, ops_done, mem_row, mem_pix} !== {1'b1, 45'd0}) begin
            errors++; $display("FAIL mid_reset_vals: got %h", {cmd_ready, eng_start, eng_op, eng_abort, host_gnt, busy, err, ops_done, mem_row, mem_pix});
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(); #1;
            if (eng_start || busy) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL mid_queue_dropped: got eng_start/busy after reset, want none"); end
        cmd_valid = 1'b1; cmd_op = 2'd3;
        step();
        cmd_valid = 1'b0; #1;
        wait_start(1'b0, "mid_restart");
        checks++;
        if (eng_op !== 2'd3) begin errors++; $display("FAIL mid_restart_op: got %0d want 3", eng_op); end
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0; #1;
        checks++;
        if (ops_done !== 8'd1) begin errors++; $display("FAIL mid_ops: got %0d want 1", ops_done); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; eng_done = 1'b0;
        eng_row = '0; eng_col = '0; eng_we = 1'b0; eng_pix = '0;
        host_req = 1'b0; host_row = '0; host_col = '0; host_we = 1'b0; host_pix = '0;
        err_clr = 1'b0;
        test_reset();
        test_single_op();
        test_fifo_full();
        test_arbitration();
        test_timeout();
        test_collision();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
